// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC conversion scheduler: sequencer state
// encoding, oversample codes, result/accumulator widths and a helper that
// turns an oversample code into the number of conversions it requests.
// ---------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int RESULT_W = 12;   // SAR result width
    localparam int ACC_W    = 15;   // holds 8 x 4095 without overflow

    // Oversample codes: 2^code conversions are averaged.
    localparam logic [1:0] OSR_X1 = 2'd0;
    localparam logic [1:0] OSR_X2 = 2'd1;
    localparam logic [1:0] OSR_X4 = 2'd2;
    localparam logic [1:0] OSR_X8 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Number of conversions requested by an oversample code.
    function automatic logic [3:0] conv_total(input logic [1:0] code);
        return 4'd1 << code;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser followed by a rising-edge detector.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, clears all flops
//   din   : asynchronous input
//   pulse : one clk-cycle pulse after a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/adc_conv_scheduler.sv
// ---------------------------------------------------------------------------
// adc_conv_scheduler
// Sequences one or more SAR conversions per request and averages them.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle request for an averaged conversion
//   osr             : oversample code (1/2/4/8 conversions)
//   sel_12b_in      : requested 12-bit mode
//   cal_req         : one-cycle request for a calibration conversion
//   clear_err       : clears timeout_err (a simultaneous set wins)
//   adc_done        : asynchronous done flag from the SAR FSM
//   adc_result      : SAR result
//   st_conv         : start-conversion pulse, ST_CONV_CYCLES wide
//   sel_12b, cal    : mode latched for the run, driven to the SAR FSM
//   avg_out         : averaged result, held between runs
//   avg_valid       : one-cycle pulse when avg_out updates
//   busy            : sequencer not idle
//   timeout_err     : sticky, set when adc_done does not arrive in time
//   fsm_state       : current sequencer state, for observation
// Handshake: start/cal_req are sampled only in IDLE; every other cycle they
// are ignored. adc_done is edge-sensitive and only honoured in WAIT.
// ---------------------------------------------------------------------------
module adc_conv_scheduler
    import adc_seq_pkg::*;
#(
    parameter int ST_CONV_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          osr,
    input  logic                sel_12b_in,
    input  logic                cal_req,
    input  logic                clear_err,
    input  logic                adc_done,
    input  logic [RESULT_W-1:0] adc_result,
    output logic                st_conv,
    output logic                sel_12b,
    output logic                cal,
    output logic [RESULT_W-1:0] avg_out,
    output logic                avg_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          fsm_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    logic [1:0]        osr_q;
    logic              cal_run;
    logic [3:0]        st_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        conv_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_shifted;
    logic              done_edge;

    sync_edge_det u_done_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (adc_done),
        .pulse (done_edge)
    );

    assign acc_shifted = acc >> osr_q;
    assign fsm_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            osr_q       <= OSR_X1;
            cal_run     <= 1'b0;
            st_cnt      <= '0;
            to_cnt      <= '0;
            conv_cnt    <= '0;
            acc         <= '0;
            st_conv     <= 1'b0;
            sel_12b     <= 1'b0;
            cal         <= 1'b0;
            avg_out     <= '0;
            avg_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            // Clear first so that a timeout in the same cycle overrides it.
            if (clear_err) timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    acc      <= '0;
                    conv_cnt <= '0;
                    if (start || cal_req) begin
                        osr_q   <= osr;
                        sel_12b <= sel_12b_in;
                        cal_run <= cal_req;   // cal_req wins; start is dropped
                        cal     <= cal_req;
                        busy    <= 1'b1;
                        st_conv <= 1'b1;
                        st_cnt  <= '0;
                        state   <= ST_ARM;
                    end
                end

                // st_conv is already high on ARM entry, so it stays high for
                // exactly ST_CONV_CYCLES cycles.
                ST_ARM: begin
                    if (st_cnt == 4'(ST_CONV_CYCLES - 1)) begin
                        st_conv <= 1'b0;
                        to_cnt  <= '0;
                        state   <= ST_WAIT;
                    end else begin
                        st_cnt <= st_cnt + 4'd1;
                    end
                end

                ST_WAIT: begin
                    if (done_edge) begin
                        acc      <= acc + {{(ACC_W-RESULT_W){1'b0}}, adc_result};
                        conv_cnt <= conv_cnt + 4'd1;
                        state    <= ST_ACC;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        cal         <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_ACC: begin
                    if (cal_run) begin
                        cal   <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (conv_cnt < conv_total(osr_q)) begin
                        st_conv <= 1'b1;
                        st_cnt  <= '0;
                        state   <= ST_ARM;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    avg_out   <= acc_shifted[RESULT_W-1:0];
                    avg_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    st_conv <= 1'b0;
                    cal     <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
